// File: rtl/trigger_gen_pkg.sv
// -----------------------------------------------------------------------------
// trigger_gen_pkg
// Shared types and defaults for the multi-channel trigger generator.
//   trig_state_t : per-channel FSM state (IDLE / RUN)
//   trig_mode_t  : latched channel mode (periodic / one-shot)
//   DEF_CNT_W    : default counter / period width
//   DEF_NUM_CH   : default number of channels
// -----------------------------------------------------------------------------
package trigger_gen_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_NUM_CH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } trig_state_t;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } trig_mode_t;

endpackage : trigger_gen_pkg

// File: rtl/trigger_gen_mc_if.sv
// -----------------------------------------------------------------------------
// trigger_gen_mc_if
// Control / status bundle of the multi-channel trigger generator.
//   start, stop, nul, mode : per-channel controls (NUM_CH bits each)
//   sync_all               : global restart of every channel
//   period                 : per-channel period, channel i at [i*CNT_W +: CNT_W]
//   trigger, busy          : per-channel registered status
//   any_trigger            : OR of all trigger bits
// master drives the controls, slave (the generator) drives the status.
// -----------------------------------------------------------------------------
interface trigger_gen_mc_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);

  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       stop;
  logic [NUM_CH-1:0]       nul;
  logic                    sync_all;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*CNT_W-1:0] period;
  logic [NUM_CH-1:0]       trigger;
  logic [NUM_CH-1:0]       busy;
  logic                    any_trigger;

  modport master (
    output start, stop, nul, sync_all, mode, period,
    input  trigger, busy, any_trigger
  );

  modport slave (
    input  start, stop, nul, sync_all, mode, period,
    output trigger, busy, any_trigger
  );

endinterface : trigger_gen_mc_if

// File: rtl/trigger_channel.sv
// -----------------------------------------------------------------------------
// trigger_channel
// One programmable trigger channel: IDLE/RUN FSM, period counter, latched
// period and mode, registered trigger and busy flags.
//   i_clk     : clock, rising edge
//   i_rst     : asynchronous active-low reset
//   i_start   : effective start (own start OR global resync)
//   i_stop    : stop request (highest priority)
//   i_nul     : synchronous counter clear
//   i_mode    : 0 periodic, 1 one-shot (latched at start)
//   i_period  : period P (latched at start, P==0 means "do not start")
//   o_trigger : one-cycle trigger pulse
//   o_busy    : channel is in RUN
// -----------------------------------------------------------------------------
module trigger_channel
  import trigger_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_nul,
  input  logic             i_mode,
  input  logic [CNT_W-1:0] i_period,
  output logic             o_trigger,
  output logic             o_busy
);

  trig_state_t      r_state;
  trig_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] w_period_nxt;
  trig_mode_t       r_mode;
  trig_mode_t       w_mode_nxt;
  logic             r_trigger;
  logic             w_trigger_nxt;
  logic             r_busy;
  logic             w_finished;
  logic             w_period_nz;

  // r_period is at least 1 while in RUN, so period-1 never wraps there.
  assign w_finished  = (r_cnt == (r_period - CNT_W'(1)));
  assign w_period_nz = (i_period != {CNT_W{1'b0}});

  // Next-state, counter and latch update; priority stop > start > nul > finished.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_mode_nxt    = r_mode;
    w_trigger_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
        end else if (i_start && w_period_nz) begin
          w_state_nxt  = RUN;
          w_period_nxt = i_period;
          w_mode_nxt   = trig_mode_t'(i_mode);
          w_cnt_nxt    = {CNT_W{1'b0}};
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (i_stop) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (i_start) begin
          // Restart swallows a pulse that would have fired on this edge.
          w_cnt_nxt = {CNT_W{1'b0}};
          if (w_period_nz) begin
            w_state_nxt  = RUN;
            w_period_nxt = i_period;
            w_mode_nxt   = trig_mode_t'(i_mode);
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (i_nul) begin
          w_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_finished) begin
          w_trigger_nxt = 1'b1;
          w_cnt_nxt     = {CNT_W{1'b0}};
          if (r_mode == MODE_ONESHOT) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = RUN;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter, latches and output flags.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_period  <= {CNT_W{1'b0}};
      r_mode    <= MODE_PERIODIC;
      r_trigger <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_mode    <= w_mode_nxt;
      r_trigger <= w_trigger_nxt;
      // busy tracks the state being entered, so it drops with a one-shot pulse.
      r_busy    <= (w_state_nxt == RUN);
    end
  end

  assign o_trigger = r_trigger;
  assign o_busy    = r_busy;

endmodule : trigger_channel

// File: rtl/trigger_gen_mc.sv
// -----------------------------------------------------------------------------
// trigger_gen_mc
// Multi-channel programmable trigger generator. Each channel divides clk by
// its own runtime period and emits one-cycle registered trigger pulses in
// periodic or one-shot mode.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : trigger_gen_mc_if.slave (controls in, trigger/busy/any_trigger out)
// -----------------------------------------------------------------------------
module trigger_gen_mc
  import trigger_gen_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  trigger_gen_mc_if.slave    bus
);

  logic [NUM_CH-1:0] w_trigger;
  logic [NUM_CH-1:0] w_busy;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_start_eff;

    // sync_all acts as a start on every channel at once.
    assign w_start_eff = bus.start[g] | bus.sync_all;

    trigger_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (w_start_eff),
      .i_stop    (bus.stop[g]),
      .i_nul     (bus.nul[g]),
      .i_mode    (bus.mode[g]),
      .i_period  (bus.period[g*CNT_W +: CNT_W]),
      .o_trigger (w_trigger[g]),
      .o_busy    (w_busy[g])
    );
  end

  assign bus.trigger     = w_trigger;
  assign bus.busy        = w_busy;
  assign bus.any_trigger = |w_trigger;

endmodule : trigger_gen_mc
